// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared constants, FSM state type and digit helpers for the sequential
// BCD-to-binary converter.
//
// Contents:
//   DIGIT_W       width of one packed BCD digit
//   DIGIT_MAX     largest legal decimal digit
//   ADJ_THRESH    shifted digits at or above this value need correction
//   ADJ_SUB       correction subtracted from such a digit
//   state_t       converter FSM states
//   digit_invalid returns 1 when a 4-bit field is not a decimal digit
// ---------------------------------------------------------------------------
package bcd_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] DIGIT_MAX  = 4'd9;
    localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd8;
    localparam logic [DIGIT_W-1:0] ADJ_SUB    = 4'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
        return (d > DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
// Per-digit correction used by reverse double-dabble. After the working
// register has been shifted right by one, a BCD digit whose value is 8 or
// more received a bit that was worth 10 in the digit above, but it is now
// weighted as 8; subtracting 3 restores a correct BCD digit.
//
// Ports:
//   digit  in   4  shifted BCD digit
//   adj    out  4  corrected digit: (digit >= 8) ? digit - 3 : digit
// ---------------------------------------------------------------------------
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adj
);

    always_comb begin
        adj = digit;
        if (digit >= ADJ_THRESH) begin
            adj = digit - ADJ_SUB;
        end
    end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_seq
// Sequential packed-BCD to unsigned binary converter using reverse
// double-dabble, one result bit per clock. A request whose digits are not
// all decimal skips the conversion and reports an error immediately.
//
// Parameters:
//   DIGITS  number of BCD digits in in_bcd (default 3)
//   BIN_W   result width; 2**BIN_W must exceed 10**DIGITS - 1 (default 10)
//
// Ports:
//   clk        in   1          rising-edge clock
//   resetn     in   1          asynchronous active-low reset
//   in_valid   in   1          in_bcd carries a request
//   in_ready   out  1          converter idle, request will be accepted
//   in_bcd     in   4*DIGITS   packed BCD, digit 0 in [3:0] is least significant
//   out_valid  out  1          out_bin / out_err are valid
//   out_ready  in   1          consumer takes the result
//   out_bin    out  BIN_W      converted value (0 on error)
//   out_err    out  1          some input digit was greater than 9
// ---------------------------------------------------------------------------
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      out_bin,
    output logic                  out_err
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             state_q;
    state_t             state_d;
    logic               in_ready_d;
    logic               out_valid_d;

    logic [BCD_W-1:0]   bcd_q;
    logic [BIN_W-1:0]   bin_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [BCD_W-1:0]   shifted_bcd;
    logic [BIN_W-1:0]   shifted_bin;
    logic [BCD_W-1:0]   adj_bcd;

    logic               any_err;
    logic               accept;
    logic               last_step;

    // Digit check on the incoming word
    always_comb begin
        any_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_invalid(in_bcd[i*DIGIT_W +: DIGIT_W])) begin
                any_err = 1'b1;
            end
        end
    end

    assign accept = (state_q == IDLE) && in_valid && in_ready;

    // cnt_q counts completed steps, so the step in progress is the last one
    // when BIN_W-1 steps are already done.
    assign last_step = (cnt_q == CNT_W'(BIN_W - 1));

    // One right shift of {bcd, bin}: a zero enters the BCD MSB and the BCD
    // LSB moves into the binary MSB.
    assign shifted_bcd = {1'b0, bcd_q[BCD_W-1:1]};
    assign shifted_bin = {bcd_q[0], bin_q[BIN_W-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (shifted_bcd[g*DIGIT_W +: DIGIT_W]),
            .adj   (adj_bcd[g*DIGIT_W +: DIGIT_W])
        );
    end

    // State register; the handshake flags are registered alongside it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = any_err ? DONE : CONV;
                end
            end
            CONV: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode of the upcoming state, captured by the state register
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // Working register, step counter and result registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            out_bin <= '0;
            out_err <= 1'b0;
        end else begin
            if (accept) begin
                if (any_err) begin
                    out_bin <= '0;
                    out_err <= 1'b1;
                end else begin
                    bcd_q <= in_bcd;
                    bin_q <= '0;
                    cnt_q <= '0;
                end
            end else if (state_q == CONV) begin
                bcd_q <= adj_bcd;
                bin_q <= shifted_bin;
                cnt_q <= cnt_q + CNT_W'(1);
                if (last_step) begin
                    out_bin <= shifted_bin;
                    out_err <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
module tb_bcd_to_bin_seq;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;
    localparam int TMO    = 40;

    logic              clk;
    logic              resetn;
    logic              in_valid;
    logic              in_ready;
    logic [11:0]       in_bcd;
    logic              out_valid;
    logic              out_ready;
    logic [BIN_W-1:0]  out_bin;
    logic              out_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [11:0]      bcd;
        logic [BIN_W-1:0] bin;
        logic             err;
        int               hold;
    } vec_t;

    vec_t vecs[$];

    bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: decimal value of the digits, error if any digit exceeds 9
    task automatic ref_model(input logic [11:0] bcd, output logic [BIN_W-1:0] bin, output logic err);
        int val;
        int d;
        int w;
        val = 0;
        w   = 1;
        err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'((bcd >> (4 * i)) & 12'hF);
            if (d > 9) err = 1'b1;
            val = val + d * w;
            w = w * 10;
        end
        bin = err ? '0 : BIN_W'(val);
    endtask

    task automatic do_req(input logic [11:0] bcd, input logic [BIN_W-1:0] eb, input logic ee, input int hold);
        int lat;
        out_ready = (hold == 0);
        @(negedge clk);
        in_bcd   = bcd;
        in_valid = 1'b1;
        check("in_ready_before_accept", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < TMO) begin
            check("in_ready_busy", in_ready, 0);
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, ee ? 0 : BIN_W);
        check("out_bin", out_bin, eb);
        check("out_err", out_err, ee);
        check("in_ready_in_done", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            in_bcd   = 12'h321;
            @(posedge clk);
            #1;
            check("hold_valid", out_valid, 1);
            check("hold_bin", out_bin, eb);
            check("hold_err", out_err, ee);
            check("hold_in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("valid_drop", out_valid, 0);
        check("ready_back", in_ready, 1);
    endtask

    initial begin
        logic [BIN_W-1:0] mb;
        logic             me;
        logic [11:0]      rb;
        int               seen;

        in_valid  = 1'b0;
        in_bcd    = '0;
        out_ready = 1'b1;
        resetn    = 1'b0;

        // Reset held three cycles, outputs must sit at reset values
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_in_ready", in_ready, 1);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_bin", out_bin, 0);
            check("rst_out_err", out_err, 0);
        end
        @(negedge clk);
        resetn = 1'b1;

        vecs.push_back('{12'h999, 10'd999, 1'b0, 0});
        vecs.push_back('{12'h000, 10'd0,   1'b0, 0});
        vecs.push_back('{12'h512, 10'd512, 1'b0, 0});
        vecs.push_back('{12'h007, 10'd7,   1'b0, 0});
        vecs.push_back('{12'h0A5, 10'd0,   1'b1, 0});
        vecs.push_back('{12'hB00, 10'd0,   1'b1, 0});
        vecs.push_back('{12'h255, 10'd255, 1'b0, 5});
        vecs.push_back('{12'h090, 10'd90,  1'b0, 0});
        vecs.push_back('{12'h00F, 10'd0,   1'b1, 2});
        vecs.push_back('{12'h808, 10'd808, 1'b0, 1});

        foreach (vecs[i]) begin
            do_req(vecs[i].bcd, vecs[i].bin, vecs[i].err, vecs[i].hold);
        end

        // Reset during step 4 of a conversion
        out_ready = 1'b1;
        @(negedge clk);
        in_bcd   = 12'h888;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_bin", out_bin, 0);
        check("midrst_out_err", out_err, 0);
        @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midrst_no_valid", seen, 0);
        do_req(12'h123, 10'd123, 1'b0, 0);

        // Randomized requests against the reference model
        for (int n = 0; n < 25; n++) begin
            rb = '0;
            for (int i = 0; i < DIGITS; i++) begin
                if ($urandom_range(0, 7) == 0) rb[i*4 +: 4] = 4'($urandom_range(10, 15));
                else                           rb[i*4 +: 4] = 4'($urandom_range(0, 9));
            end
            ref_model(rb, mb, me);
            do_req(rb, mb, me, int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
